ov7670_stream_gen: RTL
======================

Name: ov7670_stream_gen

Overview:
Synthesisable OV7670 camera emulator. It drives the camera-side pins (cam_vsync, cam_href, cam_data) with YUV 4:2:2 byte order Y U Y V, on the same cam_pclk.
It feeds the capture path with known frames, for board bring-up and for closed-loop simulation without a sensor.
Timing, geometry and test pattern are set by parameters and inputs.

Parameters:
H_ACTIVE, 320, Y samples per line; each line is 2*H_ACTIVE bytes; maximum 511.
V_ACTIVE, 240, active lines per frame; maximum 511.
H_BLANK, 144, cam_pclk cycles with cam_href low after each active line; minimum 1.
VSYNC_CYCLES, 1568, cycles with cam_vsync high per frame; minimum 1.
V_BP_CYCLES, 784, cycles after cam_vsync falls and before the first line; minimum 1.
V_FP_CYCLES, 784, cycles after the last line's blank and before the next cam_vsync; minimum 1.

Ports:
cam_pclk  in  1  byte clock; all state is on its rising edge.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  run request; sampled only in IDLE and at the end of VFP.
pattern_sel  in  2  0 = solid, 1 = horizontal ramp, 2 = checkerboard, 3 = vertical bars.
y_const  in  8  luma value for the solid pattern.
cam_vsync  out  1  frame sync, active high.
cam_href  out  1  line valid, active high.
cam_data  out  8  byte stream.
frame_start  out  1  one-cycle pulse on entry to VSYNC.

Behaviour:
- Reset:
  - State goes to IDLE immediately, without waiting for a clock edge.
  - All outputs and counters are cleared to 0.
  - A reset mid-frame aborts the frame; no partial-line completion is attempted.
- Outputs are registered. They reflect the state entered on the same clock edge, with no extra pipeline stage.
- States and transitions:
  - IDLE: all outputs 0. If enable=1, go to VSYNC, pulse frame_start, and latch pattern_sel and y_const into frame registers.
  - VSYNC: cam_vsync=1 for exactly VSYNC_CYCLES cycles, then go to VBP.
  - VBP: all outputs 0 for V_BP_CYCLES cycles, then go to ACTIVE with line=0.
  - ACTIVE: cam_href=1 for exactly 2*H_ACTIVE cycles; byte counter b runs 0..2*H_ACTIVE-1. Then go to HBLANK.
  - HBLANK: cam_href=0 and cam_data=0 for H_BLANK cycles. Then:
    - if line < V_ACTIVE-1: line+1 and back to ACTIVE;
    - otherwise go to VFP.
  - VFP: all outputs 0 for V_FP_CYCLES cycles. Then go to VSYNC (with frame_start and re-latch) if enable=1, else to IDLE.
- Bytes within a line, indexed by b[1:0]:
  - b[1:0] = 0 or 2 is a Y byte for pixel x = b>>1.
  - b[1:0] = 1 is U = 8'h80; b[1:0] = 3 is V = 8'h80.
- Y value by latched pattern (y is the line index):
  - solid: y_const.
  - ramp: x[7:0]; wraps at 256.
  - checker: 8'hF0 if x[4]^y[4], else 8'h10.
  - bars: 8'hFF if x[5], else 8'h00.
- cam_data is 0 whenever cam_href=0.
- Frame length is VSYNC_CYCLES + V_BP_CYCLES + V_ACTIVE*(2*H_ACTIVE + H_BLANK) + V_FP_CYCLES cycles.
- Width rules:
  - Byte counter: 10 bits.
  - Line counter: 9 bits.
  - Phase-duration counter: 16 bits; every cycle parameter must be at most 65535 (elaboration assertion).
  - No counter ever wraps during operation.
- enable going low mid-frame: the frame completes, then the block returns to IDLE.
- pattern_sel and y_const changes mid-frame: ignored until the next frame_start.
- enable held high: frames run back to back with no IDLE cycle between VFP and VSYNC.

Decomposition:
- Package cam_pkg holds:
  - the gen_state_t enum (IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP);
  - the pattern_t enum;
  - the yuv_phase_t enum (Y0, U, Y1, V);
  - CHROMA_NEUTRAL = 8'h80.
- One combinational sub-module, yuv_pattern_pixel: inputs x, y, pattern, y_const; output the 8-bit Y value.
- The top block holds the FSM, counters and output registers.

Test Plan:
Use H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VSYNC_CYCLES=5, V_BP_CYCLES=2, V_FP_CYCLES=2; frame length is 31 cycles.
1. Reset, then enable=1 with solid pattern and y_const=8'h5A:
   - frame_start is high for 1 cycle and cam_vsync is high for 5 cycles;
   - 2 cycles later cam_href is high for 8 cycles carrying 5A 80 5A 80 5A 80 5A 80;
   - cam_href then goes low for 3 cycles, repeats for the second line, and after VFP the next frame_start arrives at cycle 31.
2. Ramp pattern with H_ACTIVE=300: Y bytes go 0,1,…,255,0,…,43; every odd byte is 8'h80; 600 href-high cycles per line.
3. Checker pattern with H_ACTIVE=64 and V_ACTIVE=40:
   - line 0, x=0..15: Y=8'h10; x=16..31: Y=8'hF0;
   - line 16, x=0: Y=8'hF0.
4. Drop enable during line 0 of frame 1: frame 1 completes all 2 lines, then cam_vsync stays 0 with the block in IDLE; change pattern_sel mid-frame and check the output is unchanged until the next frame_start.
5. Assert rst_n low asynchronously in the middle of an active byte: cam_href, cam_vsync and cam_data go to 0 before the next cam_pclk edge; after release with enable=1, the first edge starts VSYNC.
6. Loopback into camera_capture with y_threshold=8'h7F and the bars pattern: mask is 0 for x=0..31 and 1 for x=32..63, on every line.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670 stream generator.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    ACTIVE,
    HBLANK,
    VFP
  } gen_state_t;

  typedef enum logic [1:0] {
    SOLID,
    RAMP,
    CHECKER,
    BARS
  } pattern_t;

  // Byte position within a YUYV pixel pair, taken from the low two bits of the byte counter.
  typedef enum logic [1:0] {
    Y0,
    U,
    Y1,
    V
  } yuv_phase_t;

  localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;

endpackage

// File: rtl/ov7670_stream_gen_pixel.sv
// Test-pattern luma generator: pure function of pixel position and latched pattern.
module yuv_pattern_pixel
  import cam_pkg::*;
(
  input  logic [8:0] i_x,
  input  logic [8:0] i_y,
  input  pattern_t   i_pattern,
  input  logic [7:0] i_y_const,
  output logic [7:0] o_y
);

  // Only the low byte of x and bit 4 of y affect any pattern.
  logic w_unused;
  assign w_unused = ^{i_x[8], i_y[8:5], i_y[3:0]};

  // Select the luma value for the requested pattern.
  always_comb begin
    o_y = i_y_const;
    case (i_pattern)
      SOLID:   o_y = i_y_const;
      RAMP:    o_y = i_x[7:0];
      CHECKER: o_y = (i_x[4] ^ i_y[4]) ? 8'hF0 : 8'h10;
      BARS:    o_y = i_x[5] ? 8'hFF : 8'h00;
      default: o_y = i_y_const;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 camera emulator: frame/line timing FSM driving vsync, href and YUYV bytes.
//
// state  | meaning
// IDLE   | stopped, all outputs low, waiting for enable
// VSYNC  | cam_vsync high for VSYNC_CYCLES
// VBP    | vertical back porch, outputs low
// ACTIVE | cam_href high, 2*H_ACTIVE bytes of Y U Y V
// HBLANK | line blanking after each active line
// VFP    | vertical front porch; enable decides restart or stop
module ov7670_stream_gen
  import cam_pkg::*;
#(
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240,
  parameter int H_BLANK      = 144,
  parameter int VSYNC_CYCLES = 1568,
  parameter int V_BP_CYCLES  = 784,
  parameter int V_FP_CYCLES  = 784
) (
  input  logic       cam_pclk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  input  logic [7:0] y_const,
  output logic       cam_vsync,
  output logic       cam_href,
  output logic [7:0] cam_data,
  output logic       frame_start
);

  if (H_ACTIVE < 1 || H_ACTIVE > 511) begin : g_bad_h_active
    $error("H_ACTIVE out of range 1..511");
  end
  if (V_ACTIVE < 1 || V_ACTIVE > 511) begin : g_bad_v_active
    $error("V_ACTIVE out of range 1..511");
  end
  if (H_BLANK < 1 || H_BLANK > 65535) begin : g_bad_h_blank
    $error("H_BLANK out of range 1..65535");
  end
  if (VSYNC_CYCLES < 1 || VSYNC_CYCLES > 65535) begin : g_bad_vsync
    $error("VSYNC_CYCLES out of range 1..65535");
  end
  if (V_BP_CYCLES < 1 || V_BP_CYCLES > 65535) begin : g_bad_vbp
    $error("V_BP_CYCLES out of range 1..65535");
  end
  if (V_FP_CYCLES < 1 || V_FP_CYCLES > 65535) begin : g_bad_vfp
    $error("V_FP_CYCLES out of range 1..65535");
  end

  // Phase timers are loaded with duration-1 and leave the phase at terminal count zero.
  localparam logic [15:0] VSYNC_LOAD = 16'(VSYNC_CYCLES - 1);
  localparam logic [15:0] VBP_LOAD   = 16'(V_BP_CYCLES - 1);
  localparam logic [15:0] VFP_LOAD   = 16'(V_FP_CYCLES - 1);
  localparam logic [15:0] HB_LOAD    = 16'(H_BLANK - 1);
  localparam logic [9:0]  BYTE_LAST  = 10'(2 * H_ACTIVE - 1);
  localparam logic [8:0]  LINE_LAST  = 9'(V_ACTIVE - 1);

  gen_state_t r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [9:0]  r_byte, w_byte_nxt;
  logic [8:0]  r_line, w_line_nxt;
  pattern_t    r_pat;
  logic [7:0]  r_yconst;
  logic        w_latch;
  logic        r_vsync, r_href, r_fs;
  logic [7:0]  r_data, w_data_nxt;
  logic [7:0]  w_pix_y;
  yuv_phase_t  w_phase;

  // Outputs are computed for the state being entered, so pixel lookup uses next-cycle indices.
  yuv_pattern_pixel u_pixel (
    .i_x       (w_byte_nxt[9:1]),
    .i_y       (w_line_nxt),
    .i_pattern (r_pat),
    .i_y_const (r_yconst),
    .o_y       (w_pix_y)
  );

  assign w_phase = yuv_phase_t'(w_byte_nxt[1:0]);

  // Next-state, timer, byte/line counter and output-data decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_byte_nxt  = r_byte;
    w_line_nxt  = r_line;
    w_latch     = 1'b0;
    w_data_nxt  = 8'h00;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = VSYNC;
          w_cnt_nxt   = VSYNC_LOAD;
          w_latch     = 1'b1;
        end
      end
      VSYNC: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt = VBP;
          w_cnt_nxt   = VBP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      VBP: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt = ACTIVE;
          w_byte_nxt  = 10'd0;
          w_line_nxt  = 9'd0;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ACTIVE: begin
        if (r_byte == BYTE_LAST) begin
          w_state_nxt = HBLANK;
          w_cnt_nxt   = HB_LOAD;
          w_byte_nxt  = 10'd0;
        end else begin
          w_byte_nxt = r_byte + 10'd1;
        end
      end
      HBLANK: begin
        if (r_cnt != 16'd0) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end else if (r_line < LINE_LAST) begin
          w_state_nxt = ACTIVE;
          w_byte_nxt  = 10'd0;
          w_line_nxt  = r_line + 9'd1;
        end else begin
          w_state_nxt = VFP;
          w_cnt_nxt   = VFP_LOAD;
        end
      end
      VFP: begin
        if (r_cnt != 16'd0) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end else if (enable) begin
          w_state_nxt = VSYNC;
          w_cnt_nxt   = VSYNC_LOAD;
          w_latch     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
    if (w_state_nxt == ACTIVE) begin
      w_data_nxt = (w_phase == U || w_phase == V) ? CHROMA_NEUTRAL : w_pix_y;
    end
  end

  // State, counters, frame-latched settings and registered outputs.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 16'd0;
      r_byte   <= 10'd0;
      r_line   <= 9'd0;
      r_pat    <= SOLID;
      r_yconst <= 8'h00;
      r_vsync  <= 1'b0;
      r_href   <= 1'b0;
      r_fs     <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_byte  <= w_byte_nxt;
      r_line  <= w_line_nxt;
      if (w_latch) begin
        r_pat    <= pattern_t'(pattern_sel);
        r_yconst <= y_const;
      end
      r_vsync <= (w_state_nxt == VSYNC);
      r_href  <= (w_state_nxt == ACTIVE);
      r_fs    <= w_latch;
      r_data  <= w_data_nxt;
    end
  end

  assign cam_vsync   = r_vsync;
  assign cam_href    = r_href;
  assign cam_data    = r_data;
  assign frame_start = r_fs;

endmodule
